// File: rtl/program_sequencer_if.sv
// Instruction-memory fetch channel between the program sequencer and the
// instruction memory: request/address out, acknowledge/data back.
interface program_sequencer_if #(
    parameter int PC_WIDTH = 16
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [15:0]         imem_data;

    modport master (output imem_req, imem_addr, input imem_ack, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/program_sequencer.sv
// Fetch/execute controller: owns PC and IR, fetches over the imem channel,
// strobes one execute cycle per instruction and selects the next PC.
module program_sequencer #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    program_sequencer_if.master imem,
    output logic [15:0]         IR,
    input  logic [19:0]         CW,
    input  logic                Z,
    input  logic                N,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic                exec_en,
    output logic [PC_WIDTH-1:0] PC,
    output logic                halted,
    output logic [15:0]         retired
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] next_pc_s;
    logic [PC_WIDTH-1:0] offset_s;
    logic [15:0]         ir_r;
    logic [15:0]         retired_r;
    logic                imem_req_r;
    logic                exec_en_r;
    logic                halted_r;
    logic                cond_s;
    logic                halt_s;
    logic                unused_cw_s;

    assign unused_cw_s = ^CW[19:3];

    // Next-PC selection from PL/JB/BC and the status flags; all arithmetic wraps.
    always_comb begin
        offset_s  = {{(PC_WIDTH-6){ir_r[8]}}, ir_r[8:6], ir_r[2:0]};
        cond_s    = CW[0] ? N : Z;
        next_pc_s = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        if (CW[2] && CW[1]) begin
            next_pc_s = jump_target;
        end else if (CW[2] && cond_s) begin
            next_pc_s = pc_r + offset_s;
        end else begin
            next_pc_s = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        end
        halt_s = (next_pc_s == pc_r);
    end

    // State transition decode; imem_ack only matters while fetching.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:    next_state_s = run ? ST_FETCH : ST_IDLE;
            ST_FETCH:   next_state_s = imem.imem_ack ? ST_EXECUTE : ST_FETCH;
            ST_EXECUTE: begin
                if (halt_s) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT:    next_state_s = ST_HALT;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Sequencer state, PC/IR and registered strobes; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            ir_r       <= 16'h0000;
            retired_r  <= 16'h0000;
            imem_req_r <= 1'b0;
            exec_en_r  <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            imem_req_r <= (next_state_s == ST_FETCH);
            exec_en_r  <= (next_state_s == ST_EXECUTE);
            if ((state_r == ST_FETCH) && imem.imem_ack) begin
                ir_r <= imem.imem_data;
            end
            if (state_r == ST_EXECUTE) begin
                pc_r      <= next_pc_s;
                retired_r <= retired_r + 16'd1;
                if (halt_s) begin
                    halted_r <= 1'b1;
                end
            end
        end
    end

    assign imem.imem_req  = imem_req_r;
    assign imem.imem_addr = pc_r;
    assign IR             = ir_r;
    assign PC             = pc_r;
    assign exec_en        = exec_en_r;
    assign halted         = halted_r;
    assign retired        = retired_r;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a memory responder serves fetches and
// predicts each instruction's outcome; a monitor checks every execute strobe.
module tb_program_sequencer;

    typedef struct {
        logic [15:0] word;
        logic        z;
        logic        n;
        logic [15:0] jt;
        int          delay;
        bit          rnd;
    } item_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
        logic [15:0] next;
        logic [15:0] ret;
        bit          halt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] ir;
    logic [19:0] cw;
    logic        z_d = 1'b0;
    logic        n_d = 1'b0;
    logic [15:0] jt_d = 16'h0000;
    logic        exec_en;
    logic [15:0] pc;
    logic        halted;
    logic [15:0] retired;

    int errors = 0;
    int checks = 0;

    item_t item_q[$];
    exp_t  exp_q[$];
    int    model_pc = 0;
    int    model_ret = 0;
    logic [15:0] last_word = 16'h0000;
    bit    post = 1'b0;

    program_sequencer_if #(.PC_WIDTH(16)) imem ();

    program_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem        (imem),
        .IR          (ir),
        .CW          (cw),
        .Z           (z_d),
        .N           (n_d),
        .jump_target (jt_d),
        .exec_en     (exec_en),
        .PC          (pc),
        .halted      (halted),
        .retired     (retired)
    );

    // Stand-in decoder: PL from the two top opcode bits, JB from bit 13, BC from bit 9.
    assign cw = {17'h00000, ir[15] & ir[14], ir[13], ir[9]};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, got no event expected one", name);
    endtask

    // Instruction-set level next PC: jump, conditional relative branch, or +1, modulo 2^16.
    function automatic int ref_next(input int a, input logic [15:0] w, input logic z,
                                    input logic n, input logic [15:0] jt);
        bit pl, jb, bc;
        int off;
        pl = w[15] & w[14];
        jb = w[13];
        bc = w[9];
        off = int'({w[8:6], w[2:0]});
        if (off >= 32) off = off - 64;
        if (pl && jb) return int'(jt);
        if (pl && (bc ? n : z)) return (a + off + 65536) % 65536;
        return (a + 1) % 65536;
    endfunction

    // Memory responder: applies the requested wait states, acks, and predicts the outcome.
    initial begin : responder
        int    wait_cnt;
        bit    waiting;
        item_t it;
        exp_t  e;
        int    nx;
        wait_cnt = 0;
        waiting  = 1'b0;
        imem.imem_ack  = 1'b0;
        imem.imem_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                imem.imem_ack = 1'b1;
                model_pc  = 0;
                model_ret = 0;
                last_word = 16'h0000;
                waiting   = 1'b0;
                wait_cnt  = 0;
                exp_q.delete();
            end else if (imem.imem_ack) begin
                imem.imem_ack = 1'b0;
            end else if (imem.imem_req && item_q.size() > 0) begin
                if (!waiting) begin
                    waiting  = 1'b1;
                    wait_cnt = item_q[0].delay;
                end
                check("fetch_addr", 32'(imem.imem_addr), 32'(model_pc));
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    check("wait_exec_en", 32'(exec_en), 32'd0);
                    check("wait_ir", 32'(ir), 32'(last_word));
                end else begin
                    it = item_q.pop_front();
                    nx = ref_next(model_pc, it.word, it.z, it.n, it.jt);
                    if (it.rnd && nx == model_pc) begin
                        if (it.word[15] & it.word[14] & it.word[13]) it.jt = 16'(model_pc + 1);
                        else it.word[0] = 1'b1;
                        nx = ref_next(model_pc, it.word, it.z, it.n, it.jt);
                    end
                    imem.imem_ack  = 1'b1;
                    imem.imem_data = it.word;
                    z_d  = it.z;
                    n_d  = it.n;
                    jt_d = it.jt;
                    model_ret = (model_ret + 1) % 65536;
                    e.addr = 16'(model_pc);
                    e.word = it.word;
                    e.next = 16'(nx);
                    e.ret  = 16'(model_ret);
                    e.halt = (nx == model_pc);
                    exp_q.push_back(e);
                    last_word = it.word;
                    model_pc  = nx;
                    waiting   = 1'b0;
                end
            end
        end
    end

    // Monitor: every execute strobe must match the oldest prediction, then the PC it produced.
    initial begin : monitor
        exp_t cur;
        bit   prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                post    = 1'b0;
                prev_en = 1'b0;
            end else begin
                if (post) begin
                    check("next_pc", 32'(pc), 32'(cur.next));
                    check("retired", 32'(retired), 32'(cur.ret));
                    check("halted", 32'(halted), 32'(cur.halt));
                    post = 1'b0;
                end
                if (exec_en) begin
                    check("exec_gap", 32'(prev_en), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_exec", 32'(exec_en), 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("exec_pc", 32'(pc), 32'(cur.addr));
                        check("exec_ir", 32'(ir), 32'(cur.word));
                        post = 1'b1;
                    end
                end
                prev_en = exec_en;
            end
        end
    end

    task automatic push(input logic [15:0] w, input logic z, input logic n,
                        input logic [15:0] jt, input int d, input bit rnd);
        item_t it;
        it.word = w; it.z = z; it.n = n; it.jt = jt; it.delay = d; it.rnd = rnd;
        item_q.push_back(it);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((item_q.size() > 0 || exp_q.size() > 0 || post) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) timeout(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b1;
        @(negedge clk);
        item_q.delete();
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_req", 32'(imem.imem_req), 32'd0);
        check("rst_exec_en", 32'(exec_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", 32'(imem.imem_req), 32'd1);
    endtask

    initial begin : main
        int k;
        logic [15:0] ret_snap;
        do_reset();

        // Straight line with a 3-cycle wait at PC=2, then branch/jump cases.
        push(16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        push(16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        push(16'h0000, 1'b0, 1'b0, 16'h0000, 3, 1'b0);
        push(16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        push(16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        push(16'hC1C6, 1'b1, 1'b0, 16'h0000, 0, 1'b0);
        push(16'h0000, 1'b0, 1'b0, 16'h0000, 1, 1'b0);
        push(16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        push(16'hC1C6, 1'b0, 1'b1, 16'h0000, 0, 1'b0);
        push(16'hE000, 1'b0, 1'b0, 16'h0005, 2, 1'b0);
        push(16'hC3C6, 1'b0, 1'b1, 16'h0000, 0, 1'b0);
        push(16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        push(16'hE000, 1'b0, 1'b0, 16'h0040, 0, 1'b0);
        drain("directed_drain");
        check("pc_at_40", 32'(pc), 32'h40);

        // Drop run while the fetch at 0x40 is stalled.
        push(16'h0000, 1'b0, 1'b0, 16'h0000, 4, 1'b0);
        k = 0;
        while (!(imem.imem_req && imem.imem_addr == 16'h0040) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) timeout("wait_req_40");
        run = 1'b0;
        drain("run_gate_drain");
        repeat (3) begin
            @(negedge clk);
            check("idle_req", 32'(imem.imem_req), 32'd0);
        end
        check("idle_pc", 32'(pc), 32'h41);
        run = 1'b1;

        // Self-jump halts; run stays high but nothing more happens.
        push(16'hE000, 1'b0, 1'b0, 16'h0041, 1, 1'b0);
        drain("halt_drain");
        check("halted", 32'(halted), 32'd1);
        ret_snap = retired;
        repeat (5) begin
            @(negedge clk);
            check("halt_req", 32'(imem.imem_req), 32'd0);
        end
        check("halt_retired", 32'(retired), 32'(ret_snap));
        check("halt_retired_model", 32'(retired), 32'(model_ret));

        // Wrap at 0xFFFF, then randomized instruction traffic.
        do_reset();
        push(16'hE000, 1'b0, 1'b0, 16'hFFFF, 0, 1'b0);
        push(16'h1234, 1'b1, 1'b1, 16'h0000, 0, 1'b0);
        drain("wrap_drain");
        check("wrap_pc", 32'(pc), 32'd0);
        for (int i = 0; i < 80; i++) begin
            push(16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                 int'($urandom_range(0, 3)), 1'b1);
        end
        drain("random_drain");

        // Reset in the middle of a stalled fetch abandons it.
        push(16'h0000, 1'b0, 1'b0, 16'h0000, 20, 1'b0);
        k = 0;
        while (!imem.imem_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) timeout("wait_req_midfetch");
        repeat (2) @(negedge clk);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

endmodule
